sf48_gain_scheduler: RTL and testbench

Sequences one shared seqmultNM (M=18, N=5) multiplier between the L+R and L-R gain paths of the stereo FM modulator, replacing the two dedicated multipliers in the 48 kHz front end.
On each clken_48 it forms saturated L+R and L-R, multiplies L+R by Ks and then L-R by Kd through the shared multiplier, and scales each product by 2^-SHIFT.
It presents the results to the interpolators with per-channel one-cycle ready pulses.
Everything is fully synchronous to clock; no logic is clocked by the multiplier ready.

---
 rtl/sf48_gain_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_sf48_gain_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sf48_gain_scheduler.sv
// ---------------------------------------------------------------------------
// sf48_gain_scheduler
//
// Time-shares one external sequential multiplier (18x5 signed, 23-bit
// product) between the L+R and L-R gain paths of the 48 kHz stereo FM front
// end. On each clken_48 the saturated sum/difference and both gains are
// latched. The L+R*Ks product is computed first and L-R*Kd second. Each
// product is arithmetically shifted right by SHIFT, saturated to 18 bits and
// presented with a one-cycle ready pulse.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   clken_48             48 kHz sample strobe (one clock wide)
//   LEFT, RIGHT          signed 18-bit input samples
//   Ks, Kd               unsigned 4-bit gains for L+R and L-R
//   mult_start           one-clock start pulse to the shared multiplier
//   mult_A, mult_B       multiplier operands, held from start to capture
//   mult_ready, mult_R   multiplier ready level and signed 23-bit product
//   LI_in_LpR/LmR        scaled, saturated results to the interpolators
//   ready_out_LpR/LmR    one-cycle pulses marking a result update
//   busy                 high whenever the sequencer is not idle
//   overrun              sticky: a strobe arrived while busy and was dropped
//   timeout_err          sticky: the multiplier failed to handshake in time
// ---------------------------------------------------------------------------
module sf48_gain_scheduler #(
    parameter int SHIFT   = 3,
    parameter int TIMEOUT = 63
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clken_48,
    input  logic signed [17:0] LEFT,
    input  logic signed [17:0] RIGHT,
    input  logic        [3:0]  Ks,
    input  logic        [3:0]  Kd,
    output logic               mult_start,
    output logic signed [17:0] mult_A,
    output logic        [4:0]  mult_B,
    input  logic               mult_ready,
    input  logic signed [22:0] mult_R,
    output logic signed [17:0] LI_in_LpR,
    output logic signed [17:0] LI_in_LmR,
    output logic               ready_out_LpR,
    output logic               ready_out_LmR,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_P   = 3'd1,
        WAIT_P_LO = 3'd2,
        WAIT_P_HI = 3'd3,
        START_M   = 3'd4,
        WAIT_M_LO = 3'd5,
        WAIT_M_HI = 3'd6
    } state_t;

    // Last counter value allowed while waiting; reaching it aborts.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic        [7:0]  wait_cnt_reg;
    logic signed [17:0] lpr_reg, lmr_reg;
    logic        [3:0]  ks_reg, kd_reg;
    logic signed [17:0] li_lpr_reg, li_lmr_reg;
    logic               rdy_lpr_reg, rdy_lmr_reg;
    logic               overrun_reg, timeout_reg;

    // Sum/difference at 19 bits so neither can wrap before saturation.
    logic signed [18:0] sum_wide, diff_wide;
    assign sum_wide  = {LEFT[17], LEFT} + {RIGHT[17], RIGHT};
    assign diff_wide = {LEFT[17], LEFT} - {RIGHT[17], RIGHT};

    function automatic logic signed [17:0] sat19(input logic signed [18:0] v);
        // Overflow into bit 18 means the value left the 18-bit range;
        // bit 18 still carries the true sign.
        if (v[18] != v[17])
            return v[18] ? 18'sh20000 : 18'sh1FFFF;
        return v[17:0];
    endfunction

    function automatic logic signed [17:0] scale_sat(input logic signed [22:0] p);
        logic signed [22:0] s;
        s = p >>> SHIFT;  // floor toward -inf, no rounding
        if (s > 23'sd131071)
            return 18'sh1FFFF;
        if (s < -23'sd131072)
            return 18'sh20000;
        return s[17:0];
    endfunction

    // Handshake decode shared by the four wait states.
    logic in_wait, wait_done, wait_expired;
    always_comb begin
        in_wait   = 1'b0;
        wait_done = 1'b0;
        case (state_reg)
            WAIT_P_LO, WAIT_M_LO: begin
                in_wait   = 1'b1;
                wait_done = !mult_ready;
            end
            WAIT_P_HI, WAIT_M_HI: begin
                in_wait   = 1'b1;
                wait_done = mult_ready;
            end
            default: ;
        endcase
        wait_expired = in_wait && !wait_done && (wait_cnt_reg == WAIT_LAST);
    end

    logic capture_p, capture_m;
    assign capture_p = (state_reg == WAIT_P_HI) && mult_ready;
    assign capture_m = (state_reg == WAIT_M_HI) && mult_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (clken_48) state_next = START_P;
            START_P:   state_next = WAIT_P_LO;
            WAIT_P_LO: if (!mult_ready)     state_next = WAIT_P_HI;
                       else if (wait_expired) state_next = IDLE;
            WAIT_P_HI: if (mult_ready)      state_next = START_M;
                       else if (wait_expired) state_next = IDLE;
            START_M:   state_next = WAIT_M_LO;
            WAIT_M_LO: if (!mult_ready)     state_next = WAIT_M_HI;
                       else if (wait_expired) state_next = IDLE;
            WAIT_M_HI: if (mult_ready)      state_next = IDLE;
                       else if (wait_expired) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    // Operands are decoded from state so they stay stable from START until
    // the capture cycle and fall back to zero when idle.
    always_comb begin
        mult_start = 1'b0;
        mult_A     = '0;
        mult_B     = '0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            START_P: begin
                mult_start = 1'b1;
                mult_A     = lpr_reg;
                mult_B     = {1'b0, ks_reg};
            end
            WAIT_P_LO, WAIT_P_HI: begin
                mult_A = lpr_reg;
                mult_B = {1'b0, ks_reg};
            end
            START_M: begin
                mult_start = 1'b1;
                mult_A     = lmr_reg;
                mult_B     = {1'b0, kd_reg};
            end
            WAIT_M_LO, WAIT_M_HI: begin
                mult_A = lmr_reg;
                mult_B = {1'b0, kd_reg};
            end
            default: ;
        endcase
    end

    // ---------------- datapath and flags ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            lpr_reg      <= '0;
            lmr_reg      <= '0;
            ks_reg       <= '0;
            kd_reg       <= '0;
            li_lpr_reg   <= '0;
            li_lmr_reg   <= '0;
            rdy_lpr_reg  <= 1'b0;
            rdy_lmr_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            // Counter restarts on every state change, so each wait state
            // gets its own full budget.
            if (state_next != state_reg)
                wait_cnt_reg <= '0;
            else if (in_wait)
                wait_cnt_reg <= wait_cnt_reg + 8'd1;

            if (state_reg == IDLE && clken_48) begin
                lpr_reg <= sat19(sum_wide);
                lmr_reg <= sat19(diff_wide);
                ks_reg  <= Ks;
                kd_reg  <= Kd;
            end

            // A strobe in any non-idle state, including the final capture
            // cycle, is dropped.
            if (state_reg != IDLE && clken_48)
                overrun_reg <= 1'b1;

            if (wait_expired)
                timeout_reg <= 1'b1;

            if (capture_p)
                li_lpr_reg <= scale_sat(mult_R);
            if (capture_m)
                li_lmr_reg <= scale_sat(mult_R);
            rdy_lpr_reg <= capture_p;
            rdy_lmr_reg <= capture_m;
        end
    end

    assign LI_in_LpR     = li_lpr_reg;
    assign LI_in_LmR     = li_lmr_reg;
    assign ready_out_LpR = rdy_lpr_reg;
    assign ready_out_LmR = rdy_lmr_reg;
    assign overrun       = overrun_reg;
    assign timeout_err   = timeout_reg;

endmodule

// File: tb/tb_sf48_gain_scheduler.sv
module tb_sf48_gain_scheduler;

    logic               clock = 1'b0;
    logic               reset;
    logic               clken_48;
    logic signed [17:0] LEFT, RIGHT;
    logic        [3:0]  Ks, Kd;
    logic               mult_start;
    logic signed [17:0] mult_A;
    logic        [4:0]  mult_B;
    logic               mult_ready;
    logic signed [22:0] mult_R;
    logic signed [17:0] LI_in_LpR, LI_in_LmR;
    logic               ready_out_LpR, ready_out_LmR;
    logic               busy, overrun, timeout_err;

    int checks = 0;
    int errors = 0;

    sf48_gain_scheduler #(.SHIFT(3), .TIMEOUT(63)) dut (
        .clock(clock), .reset(reset), .clken_48(clken_48),
        .LEFT(LEFT), .RIGHT(RIGHT), .Ks(Ks), .Kd(Kd),
        .mult_start(mult_start), .mult_A(mult_A), .mult_B(mult_B),
        .mult_ready(mult_ready), .mult_R(mult_R),
        .LI_in_LpR(LI_in_LpR), .LI_in_LmR(LI_in_LmR),
        .ready_out_LpR(ready_out_LpR), .ready_out_LmR(ready_out_LmR),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // Sequential multiplier model: ready drops the edge after start, rises
    // mult_lat clocks later with the product. When stuck, ignores start.
    logic               mult_stuck = 1'b0;
    int                 mult_lat   = 4;
    int                 mcnt;
    logic signed [22:0] prod_reg;
    always @(posedge clock) begin
        if (reset) begin
            mult_ready <= 1'b1;
            mult_R     <= '0;
            mcnt       <= 0;
        end else if (mult_start && !mult_stuck) begin
            mult_ready <= 1'b0;
            mcnt       <= mult_lat;
            prod_reg   <= 23'(mult_A) * 23'($signed(mult_B));
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mult_ready <= 1'b1;
                mult_R     <= prod_reg;
            end
        end
    end

    // Event counters for pulse counting and ordering.
    int cyc = 0, n_start = 0, n_lpr = 0, n_lmr = 0, lpr_cyc = 0, lmr_cyc = 0;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mult_start) n_start <= n_start + 1;
        if (ready_out_LpR) begin n_lpr <= n_lpr + 1; lpr_cyc <= cyc; end
        if (ready_out_LmR) begin n_lmr <= n_lmr + 1; lmr_cyc <= cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_clken();
        clken_48 = 1'b1;
        @(negedge clock);
        clken_48 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b required 0 within 300 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clken_48 = 1'b0; LEFT = '0; RIGHT = '0; Ks = '0; Kd = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++;
        if ({mult_start, mult_A, mult_B, LI_in_LpR, LI_in_LmR, ready_out_LpR,
             ready_out_LmR, busy, overrun, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b A=%0d B=%0d lpr=%0d lmr=%0d rl=%b rm=%b busy=%b ov=%b to=%b required all 0",
                     mult_start, mult_A, mult_B, LI_in_LpR, LI_in_LmR, ready_out_LpR,
                     ready_out_LmR, busy, overrun, timeout_err);
        end
        $display("reset: outputs after reset checked");
    endtask

    // One full sample with expected sum/diff operand on the first start.
    task automatic run_sample(input string name,
                              input int l, input int r, input int ks, input int kd,
                              input int exp_sum, input int exp_lpr, input int exp_lmr);
        int s_start, s_lpr, s_lmr;
        logic [4:0] exp_b;
        s_start = n_start; s_lpr = n_lpr; s_lmr = n_lmr;
        LEFT = 18'(l); RIGHT = 18'(r); Ks = 4'(ks); Kd = 4'(kd);
        exp_b = {1'b0, 4'(ks)};
        pulse_clken();
        checks++;
        if (mult_start !== 1'b1 || mult_A !== 18'(exp_sum) || mult_B !== exp_b) begin
            errors++;
            $display("FAIL %s_start: start=%b A=%0d B=%0d required 1 A=%0d B=%0d",
                     name, mult_start, mult_A, mult_B, exp_sum, exp_b);
        end
        // Inputs changed mid-flight must not affect this sample.
        LEFT = 18'sd777; RIGHT = -18'sd333; Ks = 4'd3; Kd = 4'd5;
        wait_idle(name);
        tick(2);
        checks++;
        if (LI_in_LpR !== 18'(exp_lpr)) begin
            errors++;
            $display("FAIL %s_lpr: LI_in_LpR=%0d required %0d", name, LI_in_LpR, exp_lpr);
        end
        checks++;
        if (LI_in_LmR !== 18'(exp_lmr)) begin
            errors++;
            $display("FAIL %s_lmr: LI_in_LmR=%0d required %0d", name, LI_in_LmR, exp_lmr);
        end
        checks++;
        if (n_lpr - s_lpr != 1 || n_lmr - s_lmr != 1 || n_start - s_start != 2) begin
            errors++;
            $display("FAIL %s_pulses: lpr=%0d lmr=%0d start=%0d required 1 1 2",
                     name, n_lpr - s_lpr, n_lmr - s_lmr, n_start - s_start);
        end
        checks++;
        if (!(lpr_cyc < lmr_cyc)) begin
            errors++;
            $display("FAIL %s_order: lpr_cycle=%0d lmr_cycle=%0d required lpr first", name, lpr_cyc, lmr_cyc);
        end
        $display("%s: L=%0d R=%0d Ks=%0d Kd=%0d -> LpR=%0d LmR=%0d", name, l, r, ks, kd, LI_in_LpR, LI_in_LmR);
    endtask

    task automatic test_nominal();
        run_sample("nominal", 1000, 500, 8, 8, 1500, 1500, 500);
    endtask

    task automatic test_saturation();
        run_sample("pos_sat", 100000, 100000, 15, 15, 131071, 131071, 0);
        run_sample("floor_ks0", -1, 0, 0, 1, -1, 0, -1);
        run_sample("floor_9", -9, 0, 1, 1, -9, -2, -2);
        run_sample("neg_sat", -100000, 100000, 15, 15, 0, 0, -131072);
    endtask

    task automatic test_overrun();
        int s_start, s_lpr, s_lmr;
        s_start = n_start; s_lpr = n_lpr; s_lmr = n_lmr;
        LEFT = 18'sd1000; RIGHT = 18'sd500; Ks = 4'd8; Kd = 4'd8;
        pulse_clken();
        tick(2);
        LEFT = 18'sd2000;
        pulse_clken();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: overrun=%b required 1", overrun);
        end
        wait_idle("overrun");
        tick(10);
        checks++;
        if (LI_in_LpR !== 18'sd1500 || LI_in_LmR !== 18'sd500) begin
            errors++;
            $display("FAIL overrun_results: lpr=%0d lmr=%0d required 1500 500", LI_in_LpR, LI_in_LmR);
        end
        checks++;
        if (n_lpr - s_lpr != 1 || n_lmr - s_lmr != 1 || n_start - s_start != 2) begin
            errors++;
            $display("FAIL overrun_pulses: lpr=%0d lmr=%0d start=%0d required 1 1 2",
                     n_lpr - s_lpr, n_lmr - s_lmr, n_start - s_start);
        end
        $display("overrun: overrun=%b LpR=%0d LmR=%0d", overrun, LI_in_LpR, LI_in_LmR);
    endtask

    task automatic test_timeout();
        int s_start, s_lpr, s_lmr;
        mult_stuck = 1'b1;
        s_start = n_start; s_lpr = n_lpr; s_lmr = n_lmr;
        pulse_clken();
        tick(63);  // last (63rd) wait cycle
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy=%b timeout_err=%b required 1 0", busy, timeout_err);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: busy=%b timeout_err=%b required 0 1", busy, timeout_err);
        end
        wait_idle("timeout");
        tick(3);
        checks++;
        if (n_lpr != s_lpr || n_lmr != s_lmr || n_start - s_start != 1) begin
            errors++;
            $display("FAIL timeout_pulses: lpr=%0d lmr=%0d start=%0d required 0 0 1",
                     n_lpr - s_lpr, n_lmr - s_lmr, n_start - s_start);
        end
        $display("timeout: timeout_err=%b busy=%b", timeout_err, busy);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        mult_stuck = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: timeout_err=%b overrun=%b required 0 0", timeout_err, overrun);
        end
        run_sample("after_timeout", 1000, 500, 8, 8, 1500, 1500, 500);
    endtask

    task automatic test_reset_mid();
        int s_lpr, s_lmr, n;
        mult_lat = 20;
        s_lpr = n_lpr; s_lmr = n_lmr;
        LEFT = 18'sd1000; RIGHT = 18'sd500; Ks = 4'd8; Kd = 4'd8;
        pulse_clken();
        n = 0;
        while (n_lpr == s_lpr && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n_lpr == s_lpr) begin
            errors++;
            $display("FAIL resetmid_lpr: LpR pulses=0 required 1 within 200 cycles");
        end
        tick(2);  // now in WAIT_M_HI
        checks++;
        if (busy !== 1'b1 || LI_in_LpR !== 18'sd1500) begin
            errors++;
            $display("FAIL resetmid_pre: busy=%b lpr=%0d required 1 1500", busy, LI_in_LpR);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if ({mult_start, mult_A, mult_B, LI_in_LpR, LI_in_LmR, ready_out_LpR,
             ready_out_LmR, busy, overrun, timeout_err} !== '0) begin
            errors++;
            $display("FAIL resetmid_outputs: start=%b A=%0d B=%0d lpr=%0d lmr=%0d busy=%b required all 0",
                     mult_start, mult_A, mult_B, LI_in_LpR, LI_in_LmR, busy);
        end
        reset = 1'b0;
        tick(30);
        checks++;
        if (n_lmr != s_lmr || busy !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_no_lmr: lmr pulses=%0d busy=%b required 0 0", n_lmr - s_lmr, busy);
        end
        mult_lat = 4;
        $display("reset_mid: LpR=%0d LmR=%0d busy=%b", LI_in_LpR, LI_in_LmR, busy);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
